centering_unit: RTL
===================

Name: centering_unit

Overview:
- Responder side of the whitening controller's GO/busy handshake for the centering stage.
- On a GO_cen level, reads N_SAMPLES samples of one channel from memory 1 and accumulates their sum, then forms the mean.
- Re-reads the samples and writes the mean-subtracted values to memory 2.
- Reports progress to the controller through CEN_busy and CEN_done.

Parameters:
- DATA_W, 16, signed sample width (two's complement).
- LOG2_N, 7, log2 of the sample count; N_SAMPLES = 2^LOG2_N = 128.

Ports:
- CLK_cen  in  1  block clock; all state changes on rising edge.
- RSTn  in  1  asynchronous active-low reset.
- GO_cen  in  1  level start from the controller; high = run/hold, low = abort/return to idle.
- CEN_busy  out  1  high while reading, accumulating or writing.
- CEN_done  out  1  high in DONE until GO_cen drops.
- mem1_rd_en  out  1  read strobe to memory 1.
- mem1_rd_addr  out  LOG2_N  read address.
- mem1_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem1_rd_en.
- mem2_wr_en  out  1  write strobe to memory 2.
- mem2_wr_addr  out  LOG2_N  write address.
- mem2_wr_data  out  DATA_W  centered sample, saturated.
- mean_out  out  DATA_W  registered mean; valid from MEAN onward, held in DONE.

Behaviour:

Reset and outputs:
- RSTn low, or GO_cen low in any state, forces IDLE on the next edge. RSTn acts immediately.
- In IDLE all outputs are 0, the accumulator is 0, and the counter is 0.
- All outputs are registered.

States: IDLE, ACC, MEAN, SUB, DONE.
- IDLE: if GO_cen=1 at edge 0, go to ACC. At edge 0 itself: CEN_busy=1, mem1_rd_en=1, mem1_rd_addr=0.
- ACC:
  - Issues reads at addr 0..127 on edges 0..127.
  - Captures mem1_rd_data on edges 1..128 into a signed DATA_W+LOG2_N accumulator, sign-extended. No overflow is possible at this width.
  - mem1_rd_en drops at edge 128. The state moves to MEAN at edge 128, after the last capture.
- MEAN (1 cycle, edge 129):
  - mean_out = accumulator >>> LOG2_N, an arithmetic shift (floor toward -inf), truncated to DATA_W. The result always fits.
  - The counter is cleared and the state moves to SUB.
- SUB:
  - Reads addr 0..127 on edges 130..257.
  - Writes on edges 131..258 with mem2_wr_addr = read addr of the previous cycle.
  - mem2_wr_data = sat(x - mean_out), computed at DATA_W+1 and clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - The state moves to DONE after the last write.
- DONE (from edge 259):
  - CEN_busy=0, CEN_done=1, no memory strobes.
  - Stays while GO_cen=1. When GO_cen=0, go to IDLE and CEN_done=0.
  - A new run requires GO_cen low for at least one edge, then high again.

Boundary conditions:
- The counter wraps 127 → 0 only at the ACC→MEAN and SUB→DONE transitions and never free-runs.
- GO_cen dropping mid-ACC/MEAN/SUB aborts: no further mem2 writes, busy=0 on the next edge, mean_out cleared.
- GO_cen high on the same edge as an abort is impossible, since abort is defined by GO_cen low.
- mem1_rd_en and mem2_wr_en are simultaneously high in SUB except on the first and last SUB cycles.
- Never writes memory 2 outside SUB.
- Total: CEN_done rises at edge 259 relative to the GO-sampling edge 0.

Test Plan:
- Ramp x[i]=i: sum 8128 → mean_out=63. mem2[0]=-63, mem2[127]=64. Exactly 128 writes. CEN_done at edge 259, busy high on edges 0..258.
- All samples = -5: mean_out=-5, all mem2 entries 0. Sum -1 case (one sample -1, rest 0): mean_out=-1 (floor), entry 0 = 0, others = +1.
- Saturation, 127×(-32768) plus one 32767: mean_out=-32257. That entry → 32767 (saturated from 65024). Others → -511.
- Abort: drop GO_cen at edge 140 (mid-SUB). Busy=0 and no writes after edge 141. A re-raise gives a full correct run from addr 0.
- Hold/restart: keep GO_cen high 20 cycles past DONE; CEN_done stays 1 with no strobes. Lower then raise GO_cen; the second run gives identical results.
- Async reset: assert RSTn low mid-ACC between edges. All outputs 0 immediately, IDLE held until RSTn and GO_cen are high.

Source files
------------

// File: rtl/centering_unit.sv
// Centering stage: sums one channel of samples from memory 1, forms the floor mean,
// then re-reads the samples and writes saturated (sample - mean) values to memory 2.
module centering_unit #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 7
) (
    input  logic              CLK_cen,
    input  logic              RSTn,
    input  logic              GO_cen,
    output logic              CEN_busy,
    output logic              CEN_done,
    output logic              mem1_rd_en,
    output logic [LOG2_N-1:0] mem1_rd_addr,
    input  logic [DATA_W-1:0] mem1_rd_data,
    output logic              mem2_wr_en,
    output logic [LOG2_N-1:0] mem2_wr_addr,
    output logic [DATA_W-1:0] mem2_wr_data,
    output logic [DATA_W-1:0] mean_out
);

    localparam int ACC_W = DATA_W + LOG2_N;
    localparam logic [LOG2_N-1:0] LAST_ADDR = {LOG2_N{1'b1}};
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_MEAN,
        S_SUB,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_en_q, rd_en_d;
    logic [LOG2_N-1:0]  rd_addr_q, rd_addr_d;
    logic               wr_en_q, wr_en_d;
    logic [LOG2_N-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [DATA_W-1:0]  mean_q, mean_d;

    logic [ACC_W-1:0]   sample_ext;
    logic [DATA_W:0]    diff;
    logic [DATA_W-1:0]  diff_sat;

    always_comb begin
        sample_ext = {{LOG2_N{mem1_rd_data[DATA_W-1]}}, mem1_rd_data};
        diff       = {mem1_rd_data[DATA_W-1], mem1_rd_data} - {mean_q[DATA_W-1], mean_q};
        // The two top bits disagree only when the difference left the DATA_W range.
        if (diff[DATA_W] != diff[DATA_W-1]) begin
            diff_sat = diff[DATA_W] ? SAT_MIN : SAT_MAX;
        end else begin
            diff_sat = diff[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        mean_d    = mean_q;

        if (!GO_cen) begin
            state_d = S_IDLE;
            acc_d   = '0;
            busy_d  = 1'b0;
            mean_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_ACC;
                    acc_d   = '0;
                    mean_d  = '0;
                    busy_d  = 1'b1;
                    rd_en_d = 1'b1;
                end
                S_ACC: begin
                    if (rd_en_q) begin
                        acc_d = acc_q + sample_ext;
                    end
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = S_MEAN;
                    end else begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
                S_MEAN: begin
                    // Upper bits of the sum are the arithmetic shift by LOG2_N.
                    mean_d  = acc_q[ACC_W-1:LOG2_N];
                    state_d = S_SUB;
                end
                S_SUB: begin
                    if (rd_en_q) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = rd_addr_q;
                        wr_data_d = diff_sat;
                        if (rd_addr_q != LAST_ADDR) begin
                            rd_en_d   = 1'b1;
                            rd_addr_d = rd_addr_q + 1'b1;
                        end
                    end else if (wr_en_q) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        rd_en_d = 1'b1;
                    end
                end
                S_DONE: begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_cen or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            mean_q    <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            mean_q    <= mean_d;
        end
    end

    assign CEN_busy     = busy_q;
    assign CEN_done     = done_q;
    assign mem1_rd_en   = rd_en_q;
    assign mem1_rd_addr = rd_addr_q;
    assign mem2_wr_en   = wr_en_q;
    assign mem2_wr_addr = wr_addr_q;
    assign mem2_wr_data = wr_data_q;
    assign mean_out     = mean_q;

endmodule
